// File: rtl/count_arb_if.sv
// Request/grant bundle between client logic and the count_arb scheduler.
interface count_arb_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [WIDTH-1:0]      count;

    modport master (
        output req, len,
        input  grant, done, busy, count
    );

    modport slave (
        input  req, len,
        output grant, done, busy, count
    );
endinterface

// File: rtl/count_arb.sv
// Round-robin scheduler sharing one down-counter interval timer
// among NREQ requesters; pulses the owner's done on expiry.
module count_arb #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic       clock,
    input  logic       _reset,
    count_arb_if.slave bus
);
    localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_last;
    logic [NREQ-1:0]  r_grant;
    logic [NREQ-1:0]  r_done;
    logic             r_busy;
    logic [WIDTH-1:0] r_count;

    logic             w_found;
    logic [IW-1:0]    w_pick;
    logic [WIDTH-1:0] w_len;
    int               w_idx;

    // First requester after the last grant, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_last) + k) % NREQ;
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = IW'(w_idx);
            end
        end
        w_len = bus.len[int'(w_pick)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            r_state <= IDLE;
            r_last  <= IW'(NREQ - 1);
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_count <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= NREQ'(1) << w_pick;
                        r_count <= w_len;
                        r_busy  <= 1'b1;
                        r_last  <= w_pick;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Completion wins over a same-cycle drop of req.
                    if (r_count == '0) begin
                        r_grant <= '0;
                        r_done  <= NREQ'(1) << r_last;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (!bus.req[r_last]) begin
                        r_grant <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_count <= r_count - WIDTH'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant = r_grant;
    assign bus.done  = r_done;
    assign bus.busy  = r_busy;
    assign bus.count = r_count;
endmodule

// File: tb/tb_count_arb.sv
// Directed bench for count_arb: reset, single, zero length,
// round-robin order, abort and reset during a run.
module tb_count_arb;
    localparam int WIDTH = 4;
    localparam int NREQ  = 4;

    logic clock;
    logic rst_n;
    int   total;
    int   bad;

    count_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    count_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clock  (clock),
        ._reset (rst_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_len(input int i, input logic [WIDTH-1:0] v);
        bus.len[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        bus.len = 16'h2222;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if ({bus.grant, bus.done, bus.busy, bus.count} !== 13'd0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got g=%b d=%b b=%b c=%0d want all 0",
                         c, bus.grant, bus.done, bus.busy, bus.count);
            end
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (bus.grant !== 4'b0001) begin
            bad++;
            $display("FAIL reset_first_grant got %b want 0001", bus.grant);
        end
        do_reset();
    endtask

    task automatic test_single();
        bus.req = 4'b0001;
        set_len(0, 4'd3);
        tick();
        set_len(0, 4'd7);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.grant !== 4'b0001 || bus.count !== 4'(3 - i) ||
                bus.busy !== 1'b1 || bus.done !== 4'b0) begin
                bad++;
                $display("FAIL single_run i=%0d got g=%b c=%0d b=%b d=%b want g=0001 c=%0d b=1 d=0000",
                         i, bus.grant, bus.count, bus.busy, bus.done, 3 - i);
            end
            tick();
        end
        total++;
        if (bus.done !== 4'b0001 || bus.grant !== 4'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done got d=%b g=%b b=%b want d=0001 g=0000 b=0",
                     bus.done, bus.grant, bus.busy);
        end
        bus.req = '0;
        tick();
        total++;
        if (bus.done !== 4'b0 || bus.grant !== 4'b0) begin
            bad++;
            $display("FAIL single_pulse_len got d=%b g=%b want 0000 0000",
                     bus.done, bus.grant);
        end
        do_reset();
    endtask

    task automatic test_zero_len();
        bus.req = 4'b0100;
        set_len(2, 4'd0);
        tick();
        total++;
        if (bus.grant !== 4'b0100 || bus.count !== 4'd0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL zero_grant got g=%b c=%0d b=%b want 0100 0 1",
                     bus.grant, bus.count, bus.busy);
        end
        tick();
        total++;
        if (bus.done !== 4'b0100 || bus.grant !== 4'b0) begin
            bad++;
            $display("FAIL zero_done got d=%b g=%b want 0100 0000",
                     bus.done, bus.grant);
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        int order[5];
        order = '{0, 1, 2, 3, 0};
        bus.len = 16'h1111;
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            logic [3:0] oh;
            oh = 4'(1 << order[n]);
            tick();
            total++;
            if (bus.grant !== oh || bus.count !== 4'd1) begin
                bad++;
                $display("FAIL rr_grant n=%0d got g=%b c=%0d want %b 1",
                         n, bus.grant, bus.count, oh);
            end
            tick();
            total++;
            if (bus.grant !== oh || bus.count !== 4'd0) begin
                bad++;
                $display("FAIL rr_hold n=%0d got g=%b c=%0d want %b 0",
                         n, bus.grant, bus.count, oh);
            end
            tick();
            total++;
            if (bus.done !== oh || bus.grant !== 4'b0) begin
                bad++;
                $display("FAIL rr_done n=%0d got d=%b g=%b want %b 0000",
                         n, bus.done, bus.grant, oh);
            end
        end
        do_reset();
    endtask

    task automatic test_abort();
        bus.len = '0;
        set_len(1, 4'd9);
        set_len(3, 4'd2);
        bus.req = 4'b0010;
        tick();
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (bus.count !== 4'd5 || bus.grant !== 4'b0010) begin
            bad++;
            $display("FAIL abort_pre got c=%0d g=%b want 5 0010",
                     bus.count, bus.grant);
        end
        bus.req = 4'b1000;
        tick();
        total++;
        if (bus.grant !== 4'b0 || bus.count !== 4'd0 ||
            bus.done !== 4'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_edge got g=%b c=%0d d=%b b=%b want 0000 0 0000 0",
                     bus.grant, bus.count, bus.done, bus.busy);
        end
        tick();
        total++;
        if (bus.grant !== 4'b1000 || bus.count !== 4'd2 || bus.done !== 4'b0) begin
            bad++;
            $display("FAIL abort_next got g=%b c=%0d d=%b want 1000 2 0000",
                     bus.grant, bus.count, bus.done);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        bus.len = '0;
        set_len(0, 4'd15);
        bus.req = 4'b0001;
        tick();
        for (int i = 0; i < 8; i++) tick();
        total++;
        if (bus.count !== 4'd7 || bus.grant !== 4'b0001) begin
            bad++;
            $display("FAIL rmid_pre got c=%0d g=%b want 7 0001",
                     bus.count, bus.grant);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.grant, bus.done, bus.busy, bus.count} !== 13'd0) begin
            bad++;
            $display("FAIL rmid_async got g=%b d=%b b=%b c=%0d want all 0",
                     bus.grant, bus.done, bus.busy, bus.count);
        end
        tick();
        total++;
        if (bus.done !== 4'b0 || bus.grant !== 4'b0) begin
            bad++;
            $display("FAIL rmid_nodone got d=%b g=%b want 0000 0000",
                     bus.done, bus.grant);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (bus.grant !== 4'b0001 || bus.count !== 4'd15) begin
            bad++;
            $display("FAIL rmid_regrant got g=%b c=%0d want 0001 15",
                     bus.grant, bus.count);
        end
        do_reset();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        bus.req = '0;
        bus.len = '0;
        test_reset();
        test_single();
        test_zero_len();
        test_round_robin();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
